// File: rtl/pir_pkg.sv
// Shared definitions for the multi-zone PIR alarm: state encoding and a
// small constant helper used to size the timers.
package pir_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    ALARM    = 2'd2,
    HOLDOFF  = 2'd3
  } alarm_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pir_debounce.sv
// One PIR channel: 2-flop synchroniser followed by a saturating debounce
// counter; confirmed is high once the enabled input has been high long enough.
module pir_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic en,
  output logic confirmed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every variable driven here gets a value before any branch, so no latch is inferred.
  always_comb begin
    cnt_d = '0;
    if (sync2_q && en) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
    end
  end

  assign confirmed = (cnt_q == CNT_MAX);

endmodule

// File: rtl/pir_zone_alarm.sv
// Multi-zone PIR alarm controller: per-channel debounce, DISARMED/ARMED/ALARM/
// HOLDOFF sequencing, sticky zone record and saturating alarm-entry counter.
module pir_zone_alarm
  import pir_pkg::*;
#(
  parameter int N_SENSORS       = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BUZZ_CYCLES     = 100,
  parameter int HOLDOFF_CYCLES  = 20,
  parameter int CNT_W           = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 turn,
  input  logic                 stop_alarm,
  input  logic [N_SENSORS-1:0] pir_sensor,
  input  logic [N_SENSORS-1:0] sensor_mask,
  output logic                 LED,
  output logic                 buzzer,
  output logic [N_SENSORS-1:0] zone,
  output logic [CNT_W-1:0]     event_count,
  output logic [1:0]           alarm_state
);

  localparam int TIMER_W = $clog2(max_int(BUZZ_CYCLES, HOLDOFF_CYCLES) + 1);
  localparam logic [TIMER_W-1:0] BUZZ_LAST = TIMER_W'(BUZZ_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(HOLDOFF_CYCLES - 1);

  logic [N_SENSORS-1:0] confirmed;

  for (genvar i = 0; i < N_SENSORS; i++) begin : g_chan
    pir_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw       (pir_sensor[i]),
      .en        (sensor_mask[i]),
      .confirmed (confirmed[i])
    );
  end

  alarm_state_e         state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [N_SENSORS-1:0] zone_q, zone_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 led_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    zone_d  = zone_q;
    count_d = count_q;
    case (state_q)
      DISARMED: begin
        timer_d = '0;
        if (turn) begin
          state_d = ARMED;
          zone_d  = '0;
        end
      end
      ARMED: begin
        timer_d = '0;
        if (!turn) begin
          state_d = DISARMED;
        end else if (|confirmed) begin
          state_d = ALARM;
          zone_d  = zone_q | confirmed;
          count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
        end
      end
      ALARM: begin
        zone_d  = zone_q | confirmed;
        timer_d = timer_q + TIMER_W'(1);
        // Disarm outranks stop; stop and timeout share a single HOLDOFF entry.
        if (!turn) begin
          state_d = DISARMED;
          timer_d = '0;
        end else if (stop_alarm || timer_q == BUZZ_LAST) begin
          state_d = HOLDOFF;
          timer_d = '0;
        end
      end
      HOLDOFF: begin
        timer_d = timer_q + TIMER_W'(1);
        if (!turn) begin
          state_d = DISARMED;
          timer_d = '0;
        end else if (timer_q == HOLD_LAST) begin
          state_d = ARMED;
          timer_d = '0;
        end
      end
      default: begin
        state_d = DISARMED;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DISARMED;
      timer_q <= '0;
      zone_q  <= '0;
      count_q <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      zone_q  <= zone_d;
      count_q <= count_d;
      led_q   <= (state_d == ALARM);
    end
  end

  assign LED         = led_q;
  assign buzzer      = led_q;
  assign zone        = zone_q;
  assign event_count = count_q;
  assign alarm_state = state_q;

endmodule
